mem_cp0: RTL and testbench
==========================

MEM_CP0 -- requirements
Module: mem_cp0

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high; clock clk.
REQ-003 SHALL have ports: we  in  1  mtc0 write enable from MEM stage.
REQ-004 SHALL have ports: addr  in  5  CP0 register number (rd field).
REQ-005 SHALL have ports: wdata  in  32  mtc0 write data.
REQ-006 SHALL have ports: rdata  out  32  mfc0 read data, combinational from current register state.
REQ-007 SHALL have ports: vpc  in  32  PC of the instruction currently in MEM.
REQ-008 SHALL have ports: bd_in  in  1  MEM instruction sits in a branch delay slot.
REQ-009 SHALL have ports: exc_in  in  5  exception code from upstream stages; 0 = none.
REQ-010 SHALL have ports: hw_int  in  6  external interrupt lines.
REQ-011 SHALL have ports: eret  in  1  eret in MEM.
REQ-012 SHALL have ports: req  out  1  take-exception pulse to flush pipeline and redirect PC to 0x0000_4180.
REQ-013 SHALL have ports: epc_out  out  32  current EPC value, eret target.

Function
REQ-014 SHALL implement SR(12): IM[15:10], EXL[1], IE[0]; other bits read 0.
REQ-015 SHALL implement Cause(13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
REQ-016 SHALL implement EPC(14) as a 32-bit register and PRId(15) as constant 0x0001_8000.
REQ-017 SHALL drive rdata to 0 for any unimplemented addr.
REQ-018 SHALL compute int_req = IE & ~EXL & |(IM & IP_next), where IP_next = hw_int (plus the timer, if enabled).
REQ-019 SHALL compute exc_req = ~EXL & (exc_in != 0).
REQ-020 SHALL drive req = int_req | exc_req combinationally in the same cycle.
REQ-021 SHALL give interrupt priority over exception: ExcCode <= 0 when int_req, else exc_in.
REQ-022 SHALL, on the clock edge with req=1, set EXL<=1, BD<=bd_in, and EPC<=bd_in ? vpc-4 : vpc (modulo 2^32).
REQ-023 SHALL have two states. NORMAL (EXL=0) goes to HANDLER on req. HANDLER (EXL=1) goes to NORMAL on eret or on an mtc0 that writes EXL=0. req is never asserted in HANDLER.
REQ-024 SHALL sample IP<=hw_int every cycle, regardless of state.
REQ-025 SHALL apply mtc0 only when we=1 and req=0: SR takes wdata[15:10,1,0]; EPC takes wdata; Cause and PRId ignore writes.
REQ-026 SHALL resolve simultaneous events with precedence req > eret > mtc0; an eret and an mtc0 to SR in the same cycle leave EXL=0.
REQ-027 SHALL return pre-update values on rdata when a write is in progress (read-before-write).

Reset
REQ-028 SHALL, when reset=1 at a rising edge, clear SR, Cause and EPC to 0; rdata, req and epc_out then reflect 0.
REQ-029 SHALL let reset override req, eret and we in the same cycle.

Configuration
REQ-030 SHALL, with macro CP0_TIMER_EN defined, add Count(9) and Compare(11), both reset to 0.
REQ-031 Count SHALL increment every cycle and wrap 0xFFFF_FFFF->0.
REQ-032 The timer pending bit SHALL set when Count==Compare and clear on an mtc0 to Compare.
REQ-033 The timer pending bit SHALL be ORed into hw_int[5] before IP sampling.
REQ-034 Count and Compare SHALL be mtc0-writable; an mtc0 to Count overrides the increment in that cycle.
REQ-035 SHALL, with CP0_TIMER_EN undefined, read addresses 9 and 11 as 0, ignore writes to them, and include no timer logic.

Verification
REQ-036 Bench SHALL cover: mtc0 SR=0x0000_0401, hw_int=6'b000001 -> req=1 same cycle; next cycle EXL=1, ExcCode=0, EPC=vpc.
REQ-037 Bench SHALL cover: SR=0, exc_in=4, vpc=0x3004, bd_in=1 -> req=1; EPC=0x3000, BD=1, Cause[6:2]=4.
REQ-038 Bench SHALL cover: EXL=1, exc_in=10 -> req=0; then eret -> EXL=0, epc_out unchanged.
REQ-039 Bench SHALL cover: we=1, addr=14, wdata=0x5000 with exc_in=8 in the same cycle -> EPC=vpc, not 0x5000.
REQ-040 Bench SHALL cover: reset asserted while EXL=1 with hw_int active -> SR=Cause=EPC=0, req=0 the following cycle.
REQ-041 Bench SHALL cover (CP0_TIMER_EN): Compare=5, SR=0x0000_8001 -> req about 5 cycles after the Count reset; mtc0 Compare clears pending.

Source files
------------

// File: rtl/mem_cp0.sv
// Coprocessor-0 block for the MEM stage: SR, Cause, EPC, PRId, exception/interrupt request and eret.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module mem_cp0 (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out
);
    localparam logic [4:0]  ADDR_COUNT   = 5'd9;
    localparam logic [4:0]  ADDR_COMPARE = 5'd11;
    localparam logic [4:0]  ADDR_SR      = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE   = 5'd13;
    localparam logic [4:0]  ADDR_EPC     = 5'd14;
    localparam logic [4:0]  ADDR_PRID    = 5'd15;
    localparam logic [31:0] PRID_VALUE   = 32'h0001_8000;

    // The FSM state is the SR.EXL bit itself.
    localparam logic [0:0] ST_NORMAL  = 1'b0;
    localparam logic [0:0] ST_HANDLER = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;

    logic [5:0]  ip_next;
    logic        exl;
    logic        int_req;
    logic        exc_req;
    logic        mtc0;

    logic unused_wdata;
    assign unused_wdata = ^{wdata[31:16], wdata[9:2]};

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tpend_q, tpend_d;

    assign ip_next = hw_int | {tpend_q, 5'b0};

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        tpend_d   = tpend_q;
        if (count_q == compare_q) begin
            tpend_d = 1'b1;
        end
        if (mtc0 && addr == ADDR_COUNT) begin
            count_d = wdata;
        end
        // A write to Compare acknowledges the timer even if it matches again.
        if (mtc0 && addr == ADDR_COMPARE) begin
            compare_d = wdata;
            tpend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            tpend_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tpend_q   <= tpend_d;
        end
    end
`else
    assign ip_next = hw_int;
`endif

    assign exl     = (state_q == ST_HANDLER);
    assign int_req = ie_q & ~exl & (|(im_q & ip_next));
    assign exc_req = ~exl & (exc_in != 5'd0);
    assign req     = int_req | exc_req;
    assign mtc0    = we & ~req;
    assign epc_out = epc_q;

    always_comb begin
        state_d   = state_q;
        im_d      = im_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ip_d      = ip_next;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (req) begin
            state_d   = ST_HANDLER;
            bd_d      = bd_in;
            epc_d     = bd_in ? (vpc - 32'd4) : vpc;
            exccode_d = int_req ? 5'd0 : exc_in;
        end else begin
            if (mtc0 && addr == ADDR_SR) begin
                im_d    = wdata[15:10];
                ie_d    = wdata[0];
                state_d = wdata[1] ? ST_HANDLER : ST_NORMAL;
            end
            if (mtc0 && addr == ADDR_EPC) begin
                epc_d = wdata;
            end
            // eret wins over an SR write to EXL in the same cycle.
            if (eret) begin
                state_d = ST_NORMAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_NORMAL;
            im_q      <= 6'd0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            im_q      <= im_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_SR:    rdata = {16'd0, im_q, 8'd0, exl, ie_q};
            ADDR_CAUSE: rdata = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
            ADDR_EPC:   rdata = epc_q;
            ADDR_PRID:  rdata = PRID_VALUE;
`ifdef CP0_TIMER_EN
            ADDR_COUNT:   rdata = count_q;
            ADDR_COMPARE: rdata = compare_q;
`endif
            default:    rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_mem_cp0.sv
// Scoreboard bench for mem_cp0: expectations are queued as stimulus is driven and drained against DUT outputs.
// Define CP0_TIMER_EN on both bench and RTL to include the timer scenario.
module tb_mem_cp0;
    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Observation kinds: 0..31 read that CP0 register, 32 = req, 33 = epc_out.
    localparam int K_REQ = 32;
    localparam int K_EPC = 33;

    string       sb_tag_q[$];
    int          sb_kind_q[$];
    logic [31:0] sb_val_q[$];

    mem_cp0 dut (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .vpc    (vpc),
        .bd_in  (bd_in),
        .exc_in (exc_in),
        .hw_int (hw_int),
        .eret   (eret),
        .req    (req),
        .epc_out(epc_out)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we     = 1'b0;
        addr   = 5'd0;
        wdata  = 32'd0;
        vpc    = 32'd0;
        bd_in  = 1'b0;
        exc_in = 5'd0;
        hw_int = 6'd0;
        eret   = 1'b0;
    endtask

    task automatic expect_val(input string tag, input int kind, input logic [31:0] val);
        sb_tag_q.push_back(tag);
        sb_kind_q.push_back(kind);
        sb_val_q.push_back(val);
    endtask

    task automatic observe(input int kind, output logic [31:0] v);
        if (kind == K_REQ) begin
            #1;
            v = {31'd0, req};
        end else if (kind == K_EPC) begin
            #1;
            v = epc_out;
        end else begin
            addr = kind[4:0];
            #1;
            v = rdata;
        end
    endtask

    task automatic drain();
        logic [31:0] obs;
        while (sb_kind_q.size() > 0) begin
            observe(sb_kind_q[0], obs);
            check_eq(sb_tag_q.pop_front(), obs, sb_val_q.pop_front());
            void'(sb_kind_q.pop_front());
        end
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

`ifdef CP0_TIMER_EN
    logic got_req;
`endif

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) tick();
        reset = 1'b0;

        expect_val("rst_sr",      12,    32'h0);
        expect_val("rst_cause",   13,    32'h0);
        expect_val("rst_epc",     14,    32'h0);
        expect_val("rst_prid",    15,    32'h0001_8000);
        expect_val("rst_unimpl3", 3,     32'h0);
        expect_val("rst_req",     K_REQ, 32'h0);
        expect_val("rst_epc_out", K_EPC, 32'h0);
        drain();
`ifdef CP0_TIMER_EN
        mtc0(5'd11, 32'hFFFF_FFFF);
`else
        mtc0(5'd9, 32'h0000_1234);
        mtc0(5'd11, 32'h0000_5678);
        expect_val("notimer_count",   9,  32'h0);
        expect_val("notimer_compare", 11, 32'h0);
        drain();
`endif

        // Interrupt taken the cycle hw_int rises once enabled.
        mtc0(5'd12, 32'h0000_0401);
        expect_val("int_sr_written", 12, 32'h0000_0401);
        drain();
        hw_int = 6'b000001;
        vpc    = 32'h0000_1000;
        expect_val("int_req", K_REQ, 32'h1);
        drain();
        expect_val("int_sr_exl",   12,    32'h0000_0403);
        expect_val("int_cause",    13,    32'h0000_0400);
        expect_val("int_epc",      14,    32'h0000_1000);
        expect_val("int_epc_out",  K_EPC, 32'h0000_1000);
        expect_val("int_req_held", K_REQ, 32'h0);
        tick();
        drain();
        eret   = 1'b1;
        hw_int = 6'd0;
        tick();
        eret = 1'b0;
        expect_val("int_eret_sr", 12, 32'h0000_0401);
        drain();
        mtc0(5'd12, 32'h0);
        expect_val("sr_cleared", 12, 32'h0);
        drain();

        // Exception in a delay slot.
        exc_in = 5'd4;
        vpc    = 32'h0000_3004;
        bd_in  = 1'b1;
        expect_val("exc_req", K_REQ, 32'h1);
        drain();
        expect_val("exc_epc",   14, 32'h0000_3000);
        expect_val("exc_cause", 13, 32'h8000_0010);
        expect_val("exc_sr",    12, 32'h0000_0002);
        tick();
        idle();
        drain();

        // No nested exception while EXL=1, then eret.
        exc_in = 5'd10;
        vpc    = 32'h0000_7777;
        expect_val("nest_req", K_REQ, 32'h0);
        drain();
        expect_val("nest_cause", 13, 32'h8000_0010);
        expect_val("nest_epc",   14, 32'h0000_3000);
        tick();
        idle();
        drain();
        eret = 1'b1;
        tick();
        idle();
        expect_val("eret_sr",      12,    32'h0);
        expect_val("eret_epc_out", K_EPC, 32'h0000_3000);
        drain();

        // Exception suppresses a same-cycle EPC write.
        we     = 1'b1;
        addr   = 5'd14;
        wdata  = 32'h0000_5000;
        exc_in = 5'd8;
        vpc    = 32'h0000_6000;
        expect_val("wexc_req", K_REQ, 32'h1);
        drain();
        expect_val("wexc_epc",   14, 32'h0000_6000);
        expect_val("wexc_cause", 13, 32'h0000_0020);
        expect_val("wexc_sr",    12, 32'h0000_0002);
        tick();
        idle();
        drain();

        // eret and SR write together: EXL ends 0, IM/IE taken.
        eret  = 1'b1;
        we    = 1'b1;
        addr  = 5'd12;
        wdata = 32'h0000_0403;
        tick();
        idle();
        expect_val("eret_mtc0_sr", 12, 32'h0000_0401);
        drain();

        // Read-before-write on EPC.
        we    = 1'b1;
        addr  = 5'd14;
        wdata = 32'h0000_5000;
        expect_val("rbw_epc", 14, 32'h0000_6000);
        drain();
        tick();
        idle();
        expect_val("mtc0_epc_out", K_EPC, 32'h0000_5000);
        drain();

        mtc0(5'd13, 32'hFFFF_FFFF);
        mtc0(5'd15, 32'h0);
        expect_val("cause_ro", 13, 32'h0000_0020);
        expect_val("prid_ro",  15, 32'h0001_8000);
        drain();

        // Interrupt beats a simultaneous exception.
        hw_int = 6'b000001;
        exc_in = 5'd5;
        vpc    = 32'h0000_8000;
        expect_val("prio_req", K_REQ, 32'h1);
        drain();
        expect_val("prio_cause", 13, 32'h0000_0400);
        expect_val("prio_epc",   14, 32'h0000_8000);
        expect_val("prio_sr",    12, 32'h0000_0403);
        tick();
        exc_in = 5'd0;
        drain();

        // Reset in the handler with an interrupt line active and a write pending.
        reset = 1'b1;
        we    = 1'b1;
        addr  = 5'd14;
        wdata = 32'h0000_ABCD;
        tick();
        reset = 1'b0;
        we    = 1'b0;
        expect_val("rst2_sr",      12,    32'h0);
        expect_val("rst2_cause",   13,    32'h0);
        expect_val("rst2_epc",     14,    32'h0);
        expect_val("rst2_req",     K_REQ, 32'h0);
        expect_val("rst2_epc_out", K_EPC, 32'h0);
        drain();
        idle();

`ifdef CP0_TIMER_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mtc0(5'd11, 32'd5);
        mtc0(5'd12, 32'h0000_8001);
        got_req = 1'b0;
        for (int i = 0; i < 20 && !got_req; i++) begin
            #1;
            if (req) got_req = 1'b1;
            else tick();
        end
        check_eq("timer_req_seen", {31'd0, got_req}, 32'h1);
        expect_val("timer_sr",    12, 32'h0000_8003);
        expect_val("timer_cause", 13, 32'h0000_8000);
        tick();
        drain();
        mtc0(5'd11, 32'd5);
        tick();
        expect_val("timer_compare", 11, 32'd5);
        expect_val("timer_ack",     13, 32'h0);
        drain();
`endif

        check_eq("sb_drained", sb_kind_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
